// File: rtl/gemm_psum_accumulator.sv
// gemm_psum_accumulator
// Sums k_tiles partial dot products per output element, narrows each finished
// sum to 2*WIDTH bits and queues it in a small output FIFO. A job produces
// num_out elements, drains the FIFO and then pulses done.
// Build option: define GEMM_PSUM_ACC_SAT_EN to saturate on narrowing;
// the default build wraps (keeps the low 2*WIDTH bits).
module gemm_psum_accumulator #(
    parameter int WIDTH      = 16,
    parameter int ACC_W      = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                cfg_k_tiles,
    input  logic [15:0]               cfg_num_out,
    input  logic                      psum_valid,
    input  logic signed [2*WIDTH-1:0] psum,
    output logic                      psum_ready,
    output logic                      out_valid,
    output logic signed [2*WIDTH-1:0] out_data,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Job configuration captured at start
    logic [7:0]       r_k_tiles;
    logic [15:0]      r_num_out;

    // Accumulation datapath
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_k_cnt;
    logic [15:0]      r_out_cnt;
    logic [ACC_W-1:0] w_sum;
    logic [PW-1:0]    w_push_data;
    logic [15:0]      w_out_cnt_inc;
    logic             w_accept;
    logic             w_last;
    logic             w_push;
    logic             w_pop;
    logic             w_job_start;

    // Output FIFO
    logic [PW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_fifo_full;
    logic             w_fifo_empty;

    assign w_fifo_full   = (r_count == FIFO_FULL_CNT);
    assign w_fifo_empty  = (r_count == '0);

    // Ready depends only on registered state, so a pop in the same cycle
    // cannot open a slot for the psum being offered.
    assign psum_ready    = (r_state == S_ACCUM) && !w_fifo_full;
    assign w_accept      = psum_valid && psum_ready;
    assign w_last        = (r_k_cnt == (r_k_tiles - 8'd1));
    assign w_push        = w_accept && w_last;
    assign w_pop         = out_valid && out_ready;
    assign w_job_start   = (r_state == S_IDLE) && start;
    assign w_out_cnt_inc = r_out_cnt + 16'd1;

    assign w_sum = r_acc + {{(ACC_W-PW){psum[PW-1]}}, psum};

`ifdef GEMM_PSUM_ACC_SAT_EN
    localparam logic [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

    // Clamp to the narrow range when the bits above the narrow sign bit
    // disagree with the wide sign bit.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_push_data = w_sum[PW-1:0];
        if (!w_sum[ACC_W-1] && (|w_sum[ACC_W-2:PW-1])) begin
            w_push_data = SAT_MAX;
        end else if (w_sum[ACC_W-1] && !(&w_sum[ACC_W-2:PW-1])) begin
            w_push_data = SAT_MIN;
        end
    end
`else
    // Two's-complement wrap: keep the low psum-width bits.
    assign w_push_data = w_sum[PW-1:0];
`endif

    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
    assign busy      = (r_state != S_IDLE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the done pulse.
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_num_out == 16'd0) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_push && (w_out_cnt_inc == r_num_out)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_fifo_empty) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Configuration capture, accumulator and element counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k_tiles <= 8'd1;
            r_num_out <= 16'd0;
            r_acc     <= '0;
            r_k_cnt   <= 8'd0;
            r_out_cnt <= 16'd0;
        end else if (w_job_start) begin
            r_k_tiles <= (cfg_k_tiles == 8'd0) ? 8'd1 : cfg_k_tiles;
            r_num_out <= cfg_num_out;
            r_acc     <= '0;
            r_k_cnt   <= 8'd0;
            r_out_cnt <= 16'd0;
        end else if (w_accept) begin
            if (w_last) begin
                r_acc     <= '0;
                r_k_cnt   <= 8'd0;
                r_out_cnt <= w_out_cnt_inc;
            end else begin
                r_acc     <= w_sum;
                r_k_cnt   <= r_k_cnt + 8'd1;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write.
    // NOTE: the storage array is deliberately not reset; the cleared count
    // marks it empty and out_data is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

endmodule

// File: tb/tb_gemm_psum_accumulator.sv
// Self-checking bench for gemm_psum_accumulator (default parameters).
// The reference model works at job level: expected outputs are the narrowed
// sums of consecutive groups of k psums, and the expected FIFO occupancy is
// (elements produced) - (elements popped).
module tb_gemm_psum_accumulator;

    localparam int D = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_k_tiles = '0;
    logic [15:0] cfg_num_out = '0;
    logic        psum_valid = 1'b0;
    logic [31:0] psum = '0;
    logic        psum_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;

    int          total_cnt = 0;
    int          bad_cnt   = 0;
    int          psq[$];
    logic [31:0] last_out;
    int          acc_at_stall;
    bit          done_seen;

    gemm_psum_accumulator #(
        .WIDTH(16),
        .ACC_W(40),
        .FIFO_DEPTH(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_k_tiles(cfg_k_tiles),
        .cfg_num_out(cfg_num_out),
        .psum_valid (psum_valid),
        .psum       (psum),
        .psum_ready (psum_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] narrow(input longint s);
        logic [63:0] v;
`ifdef GEMM_PSUM_ACC_SAT_EN
        if (s > SMAX) return 32'h7fff_ffff;
        if (s < SMIN) return 32'h8000_0000;
`endif
        v = s;
        return v[31:0];
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        start = 1'b0;
        psum_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Runs one job from the negedge in IDLE. psq supplies the leading psums,
    // random values fill the rest. out_ready is held low for the first
    // 'stall' cycles; acc_at_stall records the psums accepted by then.
    task automatic run_job(input int k_cfg, input int n_cfg, input int vpct,
                           input int rpct, input int stall);
        int          k_eff;
        int          total;
        int          accepted;
        int          produced;
        int          popped;
        int          occ;
        longint      s;
        logic [31:0] expq[$];
        bit          fin;

        k_eff = (k_cfg == 0) ? 1 : k_cfg;
        total = k_eff * n_cfg;
        while (psq.size() < total) psq.push_back(int'($urandom));
        for (int j = 0; j < n_cfg; j++) begin
            s = 0;
            for (int i = 0; i < k_eff; i++) s += longint'(psq[j*k_eff+i]);
            expq.push_back(narrow(s));
        end

        start       = 1'b1;
        cfg_k_tiles = 8'(k_cfg);
        cfg_num_out = 16'(n_cfg);
        psum_valid  = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        accepted     = 0;
        popped       = 0;
        fin          = 1'b0;
        done_seen    = 1'b0;
        acc_at_stall = -1;

        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            produced = accepted / k_eff;
            occ      = produced - popped;
            check("out_valid", out_valid, occ > 0);
            check("psum_ready", psum_ready, (produced < n_cfg) && (occ < D));
            check("busy", busy, 1'b1);
            check("done", done, (produced == n_cfg) && (occ == 0));
            if (out_valid && occ > 0) check("out_data", out_data, expq[popped]);
            if (done) begin
                fin       = 1'b1;
                done_seen = 1'b1;
            end
            if (cyc == stall) acc_at_stall = accepted;

            // Changing cfg and pulsing start mid-job must have no effect.
            cfg_k_tiles = 8'($urandom);
            cfg_num_out = 16'($urandom);
            start       = ($urandom_range(0, 7) == 0);
            psum_valid  = (accepted < total) && ($urandom_range(0, 99) < vpct);
            if (accepted < total) psum = psq[accepted];
            else psum = 32'h0;
            out_ready = (cyc >= stall) && ($urandom_range(0, 99) < rpct);

            if (out_valid && out_ready) begin
                last_out = out_data;
                popped++;
            end
            if (psum_valid && psum_ready) accepted++;
            @(negedge clk);
        end

        start      = 1'b0;
        psum_valid = 1'b0;
        out_ready  = 1'b0;
        check("job_done_seen", done_seen, 1'b1);
        check("job_pops", popped, n_cfg);
        if (!fin) apply_reset();
        check("idle_after_job", busy, 1'b0);
        psq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_psum_ready", psum_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_psum_ready", psum_ready, 1'b0);

        // Single psum, one-cycle latency
        psq = '{116};
        run_job(1, 1, 100, 100, 0);
        check("single_out", last_out, 32'd116);

        // Accumulation over three psums
        psq = '{116, -16, 4};
        run_job(3, 1, 100, 100, 0);
        check("accum_out", last_out, 32'd104);

        // Backpressure: FIFO fills with 4, then drains in order
        run_job(1, 6, 100, 100, 12);
        check("stall_pushes", acc_at_stall, 4);

        // Positive overflow on narrowing
        psq = '{32'h7fff_ffff, 1};
        run_job(2, 1, 100, 100, 0);
`ifdef GEMM_PSUM_ACC_SAT_EN
        check("overflow_pos", last_out, 32'h7fff_ffff);
`else
        check("overflow_pos", last_out, 32'h8000_0000);
`endif

        // Negative overflow on narrowing
        psq = '{32'h8000_0000, -1};
        run_job(2, 1, 100, 100, 0);
`ifdef GEMM_PSUM_ACC_SAT_EN
        check("overflow_neg", last_out, 32'h8000_0000);
`else
        check("overflow_neg", last_out, 32'h7fff_ffff);
`endif

        // k_tiles of 0 behaves as 1; num_out of 0 ends immediately
        run_job(0, 3, 80, 70, 0);
        run_job(2, 0, 100, 100, 0);

        // Reset mid-job discards partial results
        start       = 1'b1;
        cfg_k_tiles = 8'd3;
        cfg_num_out = 16'd1;
        @(negedge clk);
        start      = 1'b0;
        psum_valid = 1'b1;
        psum       = 32'd10;
        @(negedge clk);
        psum = 32'd20;
        @(negedge clk);
        psum_valid = 1'b0;
        check("midjob_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("midjob_rst_busy", busy, 1'b0);
        check("midjob_rst_out_valid", out_valid, 1'b0);
        check("midjob_rst_psum_ready", psum_ready, 1'b0);
        check("midjob_rst_done", done, 1'b0);
        check("midjob_rst_out_data", out_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        psq = '{1, 1, 1};
        run_job(3, 1, 100, 100, 0);
        check("fresh_after_reset", last_out, 32'd3);

        // Randomized jobs with random valid/ready traffic
        for (int t = 0; t < 10; t++) begin
            run_job($urandom_range(0, 4), $urandom_range(1, 8), 60, 50, 0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/gemm_psum_accumulator.md
GEMM_PSUM_ACCUMULATOR -- requirements
Module: gemm_psum_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: element width of the upstream MAC adder tree; psum width is 2*WIDTH.
REQ-002 The block SHALL have parameter ACC_W, default 40: internal accumulator width; must be at least 2*WIDTH+8.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 The block SHALL have input clk, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have input rst, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have input start, 1 bit: one-cycle job start, sampled in IDLE only.
REQ-007 The block SHALL have input cfg_k_tiles, 8 bits: psums per output element; 0 is treated as 1.
REQ-008 The block SHALL have input cfg_num_out, 16 bits: output elements per job; 0 means the job ends immediately.
REQ-009 The block SHALL have inputs psum_valid (1 bit) and psum (2*WIDTH bits, signed): partial dot product from the MAC adder tree.
REQ-010 The block SHALL have output psum_ready, 1 bit: psum accepted on a cycle where psum_valid and psum_ready are both high.
REQ-011 The block SHALL have outputs out_valid (1 bit) and out_data (2*WIDTH bits, signed), plus input out_ready (1 bit).
REQ-012 The block SHALL have outputs busy (1 bit, state not IDLE) and done (1 bit, one-cycle pulse).

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM and DRAIN.
REQ-014 IDLE SHALL go to ACCUM on start, latching cfg_k_tiles and cfg_num_out; cfg changes mid-job SHALL have no effect.
REQ-015 IDLE SHALL go to DRAIN instead when start is high and cfg_num_out is 0.
REQ-016 psum_ready SHALL equal (state==ACCUM) AND NOT fifo_full; a pop in the same cycle SHALL NOT raise psum_ready.
REQ-017 On each accepted psum, acc SHALL become acc + sign-extended psum, and k_cnt SHALL increment.
REQ-018 On the accepted psum where k_cnt == k_tiles-1, the block SHALL push acc+psum into the FIFO in that same cycle.
REQ-019 On that push, acc and k_cnt SHALL clear to 0 and out_cnt SHALL increment.
REQ-020 When the push makes out_cnt equal num_out, ACCUM SHALL go to DRAIN.
REQ-021 DRAIN SHALL wait until the FIFO is empty, then pulse done for one cycle and return to IDLE.
REQ-022 Latency SHALL be one cycle: final psum accepted at cycle t gives out_valid at t+1 when the FIFO was empty.
REQ-023 FIFO SHALL pop when out_valid and out_ready are both high.
REQ-024 Simultaneous push and pop SHALL keep the FIFO count unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 out_valid SHALL equal NOT fifo_empty, and out_data SHALL show the head entry, held stable while out_valid is high and out_ready is low.
REQ-026 The FIFO SHALL store out_data-width values produced by the REQ-036/REQ-037 conversion applied at push time.
REQ-027 start while busy SHALL be ignored.

Reset
REQ-028 rst low SHALL immediately set state to IDLE.
REQ-029 rst low SHALL clear acc, k_cnt, out_cnt and the FIFO pointers and count.
REQ-030 During reset, psum_ready, out_valid, busy and done SHALL be 0.
REQ-031 During reset, out_data SHALL read 0.
REQ-032 Reset mid-job SHALL discard all partial and buffered results.
REQ-033 After rst releases, the first start SHALL begin a clean job.

Configuration
REQ-034 The macro GEMM_PSUM_ACC_SAT_EN SHALL select the narrowing mode from ACC_W to 2*WIDTH bits.
REQ-035 The narrowing SHALL be applied when a value is pushed into the FIFO.
REQ-036 Without the macro, out_data SHALL be the low 2*WIDTH bits of acc+psum (two's-complement wrap).
REQ-037 With the macro, values above max SHALL give 2^(2*WIDTH-1)-1, and values below min SHALL give -2^(2*WIDTH-1).

Verification
REQ-038 Single psum: k_tiles=1, num_out=1, psum=116 -> out_valid one cycle later, out_data=116, then done pulse.
REQ-039 Accumulation: k_tiles=3, psums 116, -16, 4 -> one output of 104 and no output before the third psum.
REQ-040 Backpressure: DEPTH=4, out_ready=0, k_tiles=1, num_out=6 -> exactly 4 pushes and psum_ready low.
REQ-041 Backpressure release: then out_ready=1 -> outputs emerge in order and done fires after the 6th pop.
REQ-042 Overflow: k_tiles=2, WIDTH=16, psums 0x7FFFFFFF and 1 -> out_data 0x80000000 without the macro and 0x7FFFFFFF with it.
REQ-043 Reset mid-job: rst low after 2 of 3 psums -> busy=0, out_valid=0, and a fresh job with psums 1, 1, 1 gives out_data 3.
